// File: rtl/led_pattern_master.sv
// Avalon-MM master: every PERIOD_CYCLES it writes the next LED pattern, reads it back and checks it.
// Write asserts 1 cycle after a tick; requests hold while waitrequest=1, one extra tick is queued while busy.
module led_pattern_master #(
  parameter int PERIOD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mode,
  input  logic        clr_status,
  output logic        avm_m0_address,
  output logic        avm_m0_read,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  input  logic [31:0] avm_m0_readdata,
  input  logic        avm_m0_waitrequest,
  output logic [7:0]  pattern,
  output logic        busy,
  output logic        mismatch,
  output logic [7:0]  err_count,
  output logic        overrun
);

  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          tick_pending;
  logic          rd_done;
  logic          rd_fail;
  logic [7:0]    nxt;
  logic          unused_readdata_hi;

  function automatic logic [7:0] next_pattern(input logic [7:0] p, input logic m);
    if (m)
      return p + 8'd1;
    else if (p == 8'h00 || p == 8'h80)
      return 8'h01;
    else
      return {p[6:0], 1'b0};
  endfunction

  assign tick               = enable && (cnt == CNT_LAST);
  assign nxt                = next_pattern(pattern, mode);
  assign rd_done            = (state == RD) && !avm_m0_waitrequest;
  assign rd_fail            = rd_done && (avm_m0_readdata[7:0] != pattern);
  assign unused_readdata_hi = ^avm_m0_readdata[31:8];

  assign avm_m0_address   = 1'b0;
  assign avm_m0_writedata = {24'b0, pattern};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pattern      <= 8'h00;
      tick_pending <= 1'b0;
      avm_m0_read  <= 1'b0;
      avm_m0_write <= 1'b0;
      busy         <= 1'b0;
      mismatch     <= 1'b0;
      err_count    <= 8'h00;
      overrun      <= 1'b0;
    end else begin
      cnt <= (!enable || tick) ? '0 : cnt + CW'(1);

      if (clr_status) begin
        mismatch  <= 1'b0;
        err_count <= 8'h00;
        overrun   <= 1'b0;
      end

      // Only one tick can queue behind a live transaction; any further one is lost.
      if (tick && state != IDLE) begin
        if (tick_pending)
          overrun <= 1'b1;
        else
          tick_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick || tick_pending) begin
            pattern      <= nxt;
            avm_m0_write <= 1'b1;
            busy         <= 1'b1;
            tick_pending <= 1'b0;
            state        <= WR;
          end
        end
        WR: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_write <= 1'b0;
            avm_m0_read  <= 1'b1;
            state        <= RD;
          end
        end
        RD: begin
          if (rd_done) begin
            avm_m0_read <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
          // A failing compare beats a same-cycle clear.
          if (rd_fail) begin
            mismatch <= 1'b1;
            if (clr_status)
              err_count <= 8'h01;
            else if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_master.sv
// Bench for led_pattern_master: echoing slave model with programmable wait states and readback corruption.
module tb_led_pattern_master;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        clr_status = 1'b0;
  logic        avm_m0_address, avm_m0_read, avm_m0_write;
  logic [31:0] avm_m0_writedata, avm_m0_readdata;
  logic        avm_m0_waitrequest;
  logic [7:0]  pattern, err_count;
  logic        busy, mismatch, overrun;

  always #5 clk = ~clk;

  led_pattern_master #(.PERIOD_CYCLES(P)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .clr_status(clr_status),
    .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
    .avm_m0_writedata(avm_m0_writedata), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_waitrequest(avm_m0_waitrequest), .pattern(pattern), .busy(busy),
    .mismatch(mismatch), .err_count(err_count), .overrun(overrun)
  );

  // Slave model: stores writes, returns them (optionally corrupted) with zero read latency.
  logic [7:0]  mem = 8'h00;
  logic [23:0] upper = 24'h0;
  logic [7:0]  xor_mask = 8'h00;
  logic        hold_wait = 1'b0;
  int          wr_wait = 0, rd_wait = 0, wcnt = 0, rcnt = 0;

  assign avm_m0_waitrequest = hold_wait || (avm_m0_write && wcnt < wr_wait) ||
                              (avm_m0_read && rcnt < rd_wait);
  assign avm_m0_readdata    = {upper, mem ^ xor_mask};

  always @(posedge clk) begin
    if (avm_m0_write && !avm_m0_waitrequest) mem <= avm_m0_writedata[7:0];
    wcnt <= (avm_m0_write && avm_m0_waitrequest) ? wcnt + 1 : 0;
    rcnt <= (avm_m0_read && avm_m0_waitrequest) ? rcnt + 1 : 0;
  end

  int n_checks = 0, n_fail = 0;
  int wr_acc = 0, rd_acc = 0, cyc = 0, prev_cyc = 0;
  bit sb_on = 0, chk_gap = 0, prev_valid = 0, rw_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard pop on every accepted write.
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_m0_read && avm_m0_write) rw_bad = 1;
      if (avm_m0_address !== 1'b0) rw_bad = 1;
      if (avm_m0_read && !avm_m0_waitrequest) rd_acc++;
      if (avm_m0_write && !avm_m0_waitrequest) begin
        wr_acc++;
        if (sb_on) begin
          if (exp_q.size() > 0) chk("wdata", avm_m0_writedata, {24'h0, exp_q.pop_front()});
          else chk("sb_qsize", exp_q.size(), 1);
        end
        if (chk_gap) begin
          if (prev_valid) chk("tick_gap", cyc - prev_cyc, P);
          prev_cyc   = cyc;
          prev_valid = 1;
        end
      end
      if (!chk_gap) prev_valid = 0;
    end
  end

  task automatic wait_writes(input int target, input int budget);
    int b = 0;
    while (wr_acc < target && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    if (wr_acc < target) chk("wr_timeout", wr_acc, target);
  endtask

  task automatic wait_idle();
    int b = 0;
    @(negedge clk);
    while (busy && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Call at a negedge right after raising enable; counts edges until write is seen.
  task automatic measure_first_write(output int n);
    n = 0;
    while (!avm_m0_write && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, avm_m0_write, 0);
    chk({tag, "_read"}, avm_m0_read, 0);
    chk({tag, "_wdata"}, avm_m0_writedata, 0);
    chk({tag, "_pattern"}, pattern, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_errcnt"}, err_count, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int n, w0, r0, wcyc, rcyc, bcyc, b;
    bit stable;
    logic [31:0] wd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_address", avm_m0_address, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Walking one: 01..80 then wrap to 01
    sb_on = 1; chk_gap = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h01);
    enable = 1'b1;
    measure_first_write(n);
    chk("first_lat", n, P);
    wait_writes(9, 60);
    chk("walk_pattern", pattern, 8'h01);
    chk("walk_mismatch", mismatch, 0);

    // Count mode from 0x01 through 0xFE, 0xFF, 0x00 with junk upper readdata
    mode = 1'b1;
    upper = 24'hABCDEF;
    for (int k = 2; k <= 256; k++) exp_q.push_back(8'(k));
    wait_writes(9 + 255, 255 * P + 40);
    enable = 1'b0;
    wait_idle();
    chk("count_pattern", pattern, 8'h00);
    chk("count_mismatch", mismatch, 0);
    chk("count_errcnt", err_count, 0);
    chk_gap = 0;

    // Wait states: 3 in WR, 2 in RD
    mode = 1'b0; wr_wait = 3; rd_wait = 2;
    exp_q.push_back(8'h01);
    w0 = wr_acc; r0 = rd_acc;
    enable = 1'b1;
    measure_first_write(n);
    enable = 1'b0;
    chk("ws_lat", n, P);
    wcyc = 1; rcyc = 0; bcyc = busy ? 1 : 0; wd0 = avm_m0_writedata; stable = 1;
    repeat (15) begin
      @(negedge clk);
      if (avm_m0_write) begin
        wcyc++;
        if (avm_m0_writedata !== wd0) stable = 0;
      end
      if (avm_m0_read) rcyc++;
      if (busy) bcyc++;
    end
    chk("ws_write_cycles", wcyc, 4);
    chk("ws_read_cycles", rcyc, 3);
    chk("ws_busy_cycles", bcyc, 7);
    chk("ws_wdata_stable", stable, 1);
    chk("ws_wr_acc", wr_acc - w0, 1);
    chk("ws_rd_acc", rd_acc - r0, 1);
    wr_wait = 0; rd_wait = 0;
    sb_on = 0;

    // Clear and compare failure in the same cycle: failure wins
    xor_mask = 8'h01; clr_status = 1'b1;
    enable = 1'b1;
    measure_first_write(n);
    enable = 1'b0;
    wait_idle();
    clr_status = 1'b0;
    @(negedge clk);
    chk("clrrace_mismatch", mismatch, 1);
    chk("clrrace_errcnt", err_count, 1);

    // 300 corrupted readbacks saturate err_count
    w0 = wr_acc;
    mode = 1'b1; enable = 1'b1;
    wait_writes(w0 + 300, 300 * P + 40);
    enable = 1'b0;
    wait_idle();
    chk("sat_mismatch", mismatch, 1);
    chk("sat_errcnt", err_count, 255);
    chk("sat_overrun", overrun, 0);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("clr_mismatch", mismatch, 0);
    chk("clr_errcnt", err_count, 0);
    chk("clr_overrun", overrun, 0);
    xor_mask = 8'h00;

    // Stall across two periods: one pending tick, then overrun
    mode = 1'b0; hold_wait = 1'b1;
    enable = 1'b1;
    measure_first_write(n);
    repeat (5) @(negedge clk);
    chk("ovr_after_first", overrun, 0);
    repeat (4) @(negedge clk);
    chk("ovr_after_second", overrun, 1);
    enable = 1'b0;
    w0 = wr_acc; r0 = rd_acc;
    hold_wait = 1'b0;
    repeat (20) @(negedge clk);
    chk("ovr_wr_acc", wr_acc - w0, 2);
    chk("ovr_rd_acc", rd_acc - r0, 2);
    chk("ovr_busy", busy, 0);

    // Reset while stalled in RD
    rd_wait = 100;
    enable = 1'b1;
    b = 0;
    while (!avm_m0_read && b < 40) begin
      @(negedge clk);
      b++;
    end
    chk("rd_reached", avm_m0_read, 1);
    reset_n = 1'b0; enable = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rd_wait = 0;
    reset_n = 1'b1;
    @(negedge clk);
    sb_on = 1;
    exp_q.push_back(8'h01);
    w0 = wr_acc;
    enable = 1'b1;
    measure_first_write(n);
    chk("postrst_lat", n, P);
    wait_writes(w0 + 1, 20);
    enable = 1'b0;
    wait_idle();

    chk("sb_leftover", exp_q.size(), 0);
    chk("rw_exclusive_addr0", rw_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
